// File: rtl/imager_tx_pkg.sv
// Shared stream encodings, FIFO tags and state types for the imager_tx path.
package imager_tx_pkg;

    localparam int DTYPE_WIDTH = 4;

    localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_START  = 4'h0;
    localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_END    = 4'h1;
    localparam logic [DTYPE_WIDTH-1:0] DT_ROW_START    = 4'h2;
    localparam logic [DTYPE_WIDTH-1:0] DT_ROW_END      = 4'h3;
    localparam logic [DTYPE_WIDTH-1:0] DT_PIXEL        = 4'h4;
    localparam logic [DTYPE_WIDTH-1:0] DT_HEADER_START = 4'h8;
    localparam logic [DTYPE_WIDTH-1:0] DT_HEADER_DATA  = 4'h9;
    localparam logic [DTYPE_WIDTH-1:0] DT_HEADER_END   = 4'hA;

    localparam int TAG_W = 3;
    localparam logic [TAG_W-1:0] TAG_FS  = 3'd0;
    localparam logic [TAG_W-1:0] TAG_FE  = 3'd1;
    localparam logic [TAG_W-1:0] TAG_RS  = 3'd2;
    localparam logic [TAG_W-1:0] TAG_RE  = 3'd3;
    localparam logic [TAG_W-1:0] TAG_PIX = 3'd4;

    typedef enum logic [1:0] {
        WR_WAIT_FS = 2'd0,
        WR_PASS    = 2'd1,
        WR_DROP    = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        OS_IDLE   = 2'd0,
        OS_FRAME  = 2'd1,
        OS_LINE   = 2'd2,
        OS_VBLANK = 2'd3
    } out_state_t;

    function automatic logic is_stream_dtype(input logic [DTYPE_WIDTH-1:0] dt);
        return (dt == DT_FRAME_START) || (dt == DT_FRAME_END) || (dt == DT_ROW_START) ||
               (dt == DT_ROW_END) || (dt == DT_PIXEL);
    endfunction

    function automatic logic [TAG_W-1:0] dtype_to_tag(input logic [DTYPE_WIDTH-1:0] dt);
        logic [TAG_W-1:0] t;
        case (dt)
            DT_FRAME_START: t = TAG_FS;
            DT_FRAME_END:   t = TAG_FE;
            DT_ROW_START:   t = TAG_RS;
            DT_ROW_END:     t = TAG_RE;
            default:        t = TAG_PIX;
        endcase
        return t;
    endfunction

    // The counter releases on the cycle it reads zero, so loading n-1 yields exactly n cycles.
    function automatic logic [15:0] blank_load(input int n);
        return (n > 0) ? 16'(n - 1) : 16'd0;
    endfunction

endpackage

// File: rtl/imager_tx_fifo.sv
// Synchronous show-ahead FIFO: rdata presents the head entry whenever empty is low.
module imager_tx_fifo
    import imager_tx_pkg::*;
#(
    parameter int WIDTH = 15,
    parameter int AW    = 5
) (
    input  logic             clki,
    input  logic             resetb_clki,
    input  logic             flush,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [2**AW];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_wr;
    logic             do_rd;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_rd = re && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept a write.
    assign do_wr = we && (!full || do_rd);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clki or negedge resetb_clki) begin
        if (!resetb_clki) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clki) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/imager_tx.sv
// Rebuilds sensor-style fv/lv/dv timing from the pipeline dtype stream, with enforced blanking.
//   state     | meaning
//   OS_IDLE   | fv low, waiting for FRAME_START at the FIFO head
//   OS_FRAME  | fv high, lv low; lead-in or horizontal blanking
//   OS_LINE   | fv and lv high; pixels streamed out
//   OS_VBLANK | fv low; minimum frame blanking
module imager_tx
    import imager_tx_pkg::*;
#(
    parameter int PIXEL_WIDTH = 12,
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_AW     = 5,
    parameter int FV_LEAD     = 4,
    parameter int HBLANK_MIN  = 8,
    parameter int VBLANK_MIN  = 16
) (
    input  logic                   clki,
    input  logic                   resetb_clki,
    input  logic                   enable,
    input  logic                   left_justify,
    input  logic                   stat_clear,
    input  logic                   dvi,
    input  logic [DTYPE_WIDTH-1:0] dtypei,
    input  logic [DATA_WIDTH-1:0]  datai,
    output logic                   fv,
    output logic                   lv,
    output logic                   dvo,
    output logic [PIXEL_WIDTH-1:0] datao,
    output logic                   overflow,
    output logic [15:0]            frame_count
);

    localparam int FW = PIXEL_WIDTH + TAG_W;

    logic                   dv_q;
    logic [DTYPE_WIDTH-1:0] dtype_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   in_keep;
    logic [TAG_W-1:0]       in_tag;
    logic [PIXEL_WIDTH-1:0] in_pix;

    logic                   fifo_we;
    logic                   fifo_re;
    logic                   fifo_flush;
    logic [FW-1:0]          fifo_rdata;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic [TAG_W-1:0]       head_tag;
    logic [PIXEL_WIDTH-1:0] head_pix;

    wr_state_t              wr_state_q;
    logic                   abort_req_q;
    logic                   overflow_q;
    logic                   want_wr;
    logic                   room;
    logic                   abort_ack;

    out_state_t             os_q;
    logic [15:0]            cnt_q;
    logic                   fv_q;
    logic                   lv_q;
    logic                   dvo_q;
    logic [PIXEL_WIDTH-1:0] datao_q;
    logic [15:0]            frame_count_q;

    always_ff @(posedge clki or negedge resetb_clki) begin
        if (!resetb_clki) begin
            dv_q    <= 1'b0;
            dtype_q <= '0;
            data_q  <= '0;
        end else begin
            dv_q    <= dvi;
            dtype_q <= dtypei;
            data_q  <= datai;
        end
    end

    assign in_keep = dv_q && is_stream_dtype(dtype_q);
    assign in_tag  = dtype_to_tag(dtype_q);
    assign in_pix  = left_justify ? data_q[DATA_WIDTH-1 -: PIXEL_WIDTH] : data_q[PIXEL_WIDTH-1:0];

    imager_tx_fifo #(
        .WIDTH (FW),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clki        (clki),
        .resetb_clki (resetb_clki),
        .flush       (fifo_flush),
        .we          (fifo_we),
        .wdata       ({in_tag, in_pix}),
        .re          (fifo_re),
        .rdata       (fifo_rdata),
        .empty       (fifo_empty),
        .full        (fifo_full)
    );

    assign head_tag = fifo_rdata[FW-1 -: TAG_W];
    assign head_pix = fifo_rdata[PIXEL_WIDTH-1:0];

    always_comb begin
        want_wr = 1'b0;
        case (wr_state_q)
            WR_WAIT_FS: want_wr = in_keep && (in_tag == TAG_FS) && enable;
            WR_PASS:    want_wr = in_keep;
            default:    want_wr = 1'b0;
        endcase
    end

    assign room    = !fifo_full || fifo_re;
    assign fifo_we = want_wr && room && !fifo_flush;

    always_ff @(posedge clki or negedge resetb_clki) begin
        if (!resetb_clki) begin
            wr_state_q  <= WR_WAIT_FS;
            abort_req_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            case (wr_state_q)
                WR_WAIT_FS, WR_PASS: begin
                    if (want_wr) begin
                        if (!room) begin
                            overflow_q  <= 1'b1;
                            abort_req_q <= 1'b1;
                            wr_state_q  <= WR_DROP;
                        end else if (in_tag == TAG_FE) begin
                            wr_state_q <= WR_WAIT_FS;
                        end else begin
                            wr_state_q <= WR_PASS;
                        end
                    end
                end
                WR_DROP: begin
                    if (abort_ack) begin
                        abort_req_q <= 1'b0;
                        wr_state_q  <= WR_WAIT_FS;
                    end
                end
                default: wr_state_q <= WR_WAIT_FS;
            endcase
            if (stat_clear) overflow_q <= 1'b0;
        end
    end

    // An abort is only honoured once the truncated frame has fully drained.
    always_comb begin
        fifo_re   = 1'b0;
        abort_ack = 1'b0;
        case (os_q)
            OS_IDLE: begin
                fifo_re   = !fifo_empty;
                abort_ack = fifo_empty && abort_req_q;
            end
            OS_FRAME: begin
                if (fifo_empty)
                    abort_ack = abort_req_q;
                else if ((head_tag == TAG_RS) || (head_tag == TAG_PIX))
                    fifo_re = (cnt_q == '0);
                else
                    fifo_re = 1'b1;
            end
            OS_LINE: begin
                fifo_re   = !fifo_empty;
                abort_ack = fifo_empty && abort_req_q;
            end
            default: ;
        endcase
    end

    assign fifo_flush = abort_ack;

    always_ff @(posedge clki or negedge resetb_clki) begin
        if (!resetb_clki) begin
            os_q          <= OS_IDLE;
            cnt_q         <= '0;
            fv_q          <= 1'b0;
            lv_q          <= 1'b0;
            dvo_q         <= 1'b0;
            datao_q       <= '0;
            frame_count_q <= '0;
        end else begin
            dvo_q   <= 1'b0;
            datao_q <= '0;
            case (os_q)
                OS_IDLE: begin
                    fv_q <= 1'b0;
                    lv_q <= 1'b0;
                    if (fifo_re && (head_tag == TAG_FS)) begin
                        fv_q  <= 1'b1;
                        cnt_q <= blank_load(FV_LEAD);
                        os_q  <= OS_FRAME;
                    end
                end
                OS_FRAME: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                    if (abort_ack) begin
                        fv_q  <= 1'b0;
                        lv_q  <= 1'b0;
                        cnt_q <= blank_load(VBLANK_MIN);
                        os_q  <= OS_VBLANK;
                    end else if (fifo_re) begin
                        case (head_tag)
                            TAG_RS: begin
                                lv_q <= 1'b1;
                                os_q <= OS_LINE;
                            end
                            TAG_PIX: begin
                                lv_q    <= 1'b1;
                                dvo_q   <= 1'b1;
                                datao_q <= head_pix;
                                os_q    <= OS_LINE;
                            end
                            TAG_FE: begin
                                fv_q          <= 1'b0;
                                cnt_q         <= blank_load(VBLANK_MIN);
                                frame_count_q <= frame_count_q + 1'b1;
                                os_q          <= OS_VBLANK;
                            end
                            default: ;
                        endcase
                    end
                end
                OS_LINE: begin
                    if (abort_ack) begin
                        fv_q  <= 1'b0;
                        lv_q  <= 1'b0;
                        cnt_q <= blank_load(VBLANK_MIN);
                        os_q  <= OS_VBLANK;
                    end else if (fifo_re) begin
                        case (head_tag)
                            TAG_PIX: begin
                                dvo_q   <= 1'b1;
                                datao_q <= head_pix;
                            end
                            TAG_RE: begin
                                lv_q  <= 1'b0;
                                cnt_q <= blank_load(HBLANK_MIN);
                                os_q  <= OS_FRAME;
                            end
                            TAG_FE: begin
                                lv_q          <= 1'b0;
                                fv_q          <= 1'b0;
                                cnt_q         <= blank_load(VBLANK_MIN);
                                frame_count_q <= frame_count_q + 1'b1;
                                os_q          <= OS_VBLANK;
                            end
                            default: ;
                        endcase
                    end
                end
                OS_VBLANK: begin
                    fv_q <= 1'b0;
                    lv_q <= 1'b0;
                    if (cnt_q == '0)
                        os_q <= OS_IDLE;
                    else
                        cnt_q <= cnt_q - 1'b1;
                end
                default: os_q <= OS_IDLE;
            endcase
            if (stat_clear) frame_count_q <= '0;
        end
    end

    assign fv          = fv_q;
    assign lv          = lv_q;
    assign dvo         = dvo_q;
    assign datao       = datao_q;
    assign overflow    = overflow_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_imager_tx.sv
// Directed bench for imager_tx: framing, blanking, justification, overflow, enable and reset.
module tb_imager_tx;
    import imager_tx_pkg::*;

    localparam int PW = 12;
    localparam int DW = 16;
    localparam int FV_LEAD = 4;
    localparam int HBLANK_MIN = 8;
    localparam int VBLANK_MIN = 16;

    logic clki = 1'b0;
    logic resetb_clki = 1'b0;
    logic enable = 1'b1;
    logic left_justify = 1'b0;
    logic stat_clear = 1'b0;
    logic dvi = 1'b0;
    logic [DTYPE_WIDTH-1:0] dtypei = '0;
    logic [DW-1:0] datai = '0;
    logic fv, lv, dvo, overflow;
    logic [PW-1:0] datao;
    logic [15:0] frame_count;

    int total = 0;
    int bad = 0;

    always #5 clki = ~clki;

    imager_tx #(
        .PIXEL_WIDTH (PW),
        .DATA_WIDTH  (DW),
        .FIFO_AW     (5),
        .FV_LEAD     (FV_LEAD),
        .HBLANK_MIN  (HBLANK_MIN),
        .VBLANK_MIN  (VBLANK_MIN)
    ) dut (
        .clki         (clki),
        .resetb_clki  (resetb_clki),
        .enable       (enable),
        .left_justify (left_justify),
        .stat_clear   (stat_clear),
        .dvi          (dvi),
        .dtypei       (dtypei),
        .datai        (datai),
        .fv           (fv),
        .lv           (lv),
        .dvo          (dvo),
        .datao        (datao),
        .overflow     (overflow),
        .frame_count  (frame_count)
    );

    // Output timing monitor, sampled mid-cycle.
    int cyc = 0, fv_rises = 0, fv_falls = 0, viol = 0;
    int fv_rise_cyc = 0, fv_fall_cyc = -1000, lv_fall_cyc = 0;
    int min_hgap = 1000, min_vgap = 1000;
    bit first_line = 1'b0;
    int lead_q[$];
    bit lvdvo_q[$];
    bit fall_tog_q[$];
    logic [PW-1:0] pix_q[$];
    logic fv_p = 1'b0, lv_p = 1'b0;

    always @(negedge clki) begin
        cyc++;
        if (fv === 1'b1 && !fv_p) begin
            fv_rises++;
            if (cyc - fv_fall_cyc < min_vgap) min_vgap = cyc - fv_fall_cyc;
            fv_rise_cyc = cyc;
            first_line = 1'b1;
        end
        if (fv === 1'b0 && fv_p) begin
            fv_falls++;
            fv_fall_cyc = cyc;
        end
        if (lv === 1'b1 && !lv_p) begin
            if (first_line) begin
                lead_q.push_back(cyc - fv_rise_cyc);
                lvdvo_q.push_back(dvo);
                first_line = 1'b0;
            end else if (cyc - lv_fall_cyc < min_hgap) begin
                min_hgap = cyc - lv_fall_cyc;
            end
        end
        if (lv === 1'b0 && lv_p) begin
            lv_fall_cyc = cyc;
            fall_tog_q.push_back(!fv && fv_p);
        end
        if (dvo === 1'b1) pix_q.push_back(datao);
        if ((dvo === 1'b1 && !(fv && lv)) || (dvo === 1'b0 && datao !== '0) || (lv === 1'b1 && fv !== 1'b1))
            viol++;
        fv_p = (fv === 1'b1);
        lv_p = (lv === 1'b1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mon_clear();
        pix_q.delete();
        lead_q.delete();
        lvdvo_q.delete();
        fall_tog_q.delete();
        min_hgap = 1000;
        min_vgap = 1000;
    endtask

    task automatic send(input logic [DTYPE_WIDTH-1:0] dt, input logic [DW-1:0] d);
        @(negedge clki);
        dvi = 1'b1;
        dtypei = dt;
        datai = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clki);
            dvi = 1'b0;
            dtypei = '0;
            datai = '0;
        end
    endtask

    task automatic line(input int first, input int n);
        send(DT_ROW_START, 16'h0);
        for (int i = 0; i < n; i++) send(DT_PIXEL, DW'(first + i));
        send(DT_ROW_END, 16'h0);
    endtask

    task automatic wait_falls(input int target, input int budget, input string tag);
        int n = 0;
        while (fv_falls < target && n < budget) begin
            @(negedge clki);
            n++;
        end
        chk({tag, "_done"}, 32'(fv_falls >= target), 32'd1);
    endtask

    int base, rises0;

    initial begin
        // Reset state
        idle(3);
        chk("rst_fv", 32'(fv), 32'd0);
        chk("rst_lv", 32'(lv), 32'd0);
        chk("rst_dvo", 32'(dvo), 32'd0);
        chk("rst_datao", 32'(datao), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_fcnt", 32'(frame_count), 32'd0);
        @(negedge clki);
        resetb_clki = 1'b1;
        idle(2);

        // Two back-to-back frames: normal framing, then FS->PIX and FE without RE
        mon_clear();
        base = fv_falls;
        send(DT_FRAME_START, 16'h0);
        line(1, 4);
        line(5, 4);
        send(DT_FRAME_END, 16'h0);
        send(DT_FRAME_START, 16'h0);
        send(DT_PIXEL, 16'd10);
        send(DT_PIXEL, 16'd11);
        send(DT_FRAME_END, 16'h0);
        idle(1);
        wait_falls(base + 2, 400, "t12");
        chk("t12_npix", 32'(pix_q.size()), 32'd10);
        for (int i = 0; i < 8; i++) chk("t1_pix", 32'(pix_q[i]), 32'(i + 1));
        chk("t2_pix0", 32'(pix_q[8]), 32'd10);
        chk("t2_pix1", 32'(pix_q[9]), 32'd11);
        chk("t1_lead", 32'(lead_q[0]), 32'(FV_LEAD));
        chk("t2_lead", 32'(lead_q[1]), 32'(FV_LEAD));
        chk("t1_lv_no_dvo", 32'(lvdvo_q[0]), 32'd0);
        chk("t2_lv_with_dvo", 32'(lvdvo_q[1]), 32'd1);
        chk("t1_hblank", 32'(min_hgap >= HBLANK_MIN), 32'd1);
        chk("t12_vblank", 32'(min_vgap >= VBLANK_MIN), 32'd1);
        chk("t1_fall_apart", 32'(fall_tog_q[1]), 32'd0);
        chk("t2_fall_together", 32'(fall_tog_q[2]), 32'd1);
        chk("t12_fcnt", 32'(frame_count), 32'd2);

        // Left justification with header words interleaved
        mon_clear();
        base = fv_falls;
        left_justify = 1'b1;
        send(DT_FRAME_START, 16'h0);
        send(DT_HEADER_START, 16'hFFFF);
        send(DT_ROW_START, 16'h0);
        send(DT_PIXEL, 16'hABC0);
        send(DT_HEADER_DATA, 16'h5555);
        send(DT_PIXEL, 16'h1235);
        send(DT_ROW_END, 16'h0);
        send(DT_HEADER_END, 16'h7777);
        send(DT_FRAME_END, 16'h0);
        idle(1);
        wait_falls(base + 1, 200, "t3");
        chk("t3_npix", 32'(pix_q.size()), 32'd2);
        chk("t3_pix0", 32'(pix_q[0]), 32'hABC);
        chk("t3_pix1", 32'(pix_q[1]), 32'h123);
        chk("t3_fcnt", 32'(frame_count), 32'd3);
        left_justify = 1'b0;

        // Overflow: short lines back up behind horizontal blanking, then a long burst
        base = fv_falls;
        send(DT_FRAME_START, 16'h0);
        for (int k = 0; k < 12; k++) line(100 + k, 1);
        for (int k = 0; k < 40; k++) send(DT_PIXEL, DW'(200 + k));
        idle(1);
        wait_falls(base + 1, 2000, "t4_abort");
        chk("t4_ovf", 32'(overflow), 32'd1);
        chk("t4_fcnt_hold", 32'(frame_count), 32'd3);
        idle(30);
        chk("t4_fv_low", 32'(fv), 32'd0);
        chk("t4_lv_low", 32'(lv), 32'd0);
        @(negedge clki);
        stat_clear = 1'b1;
        @(negedge clki);
        stat_clear = 1'b0;
        chk("t4_clr_ovf", 32'(overflow), 32'd0);
        chk("t4_clr_fcnt", 32'(frame_count), 32'd0);
        mon_clear();
        base = fv_falls;
        send(DT_FRAME_START, 16'h0);
        line(7, 2);
        send(DT_FRAME_END, 16'h0);
        idle(1);
        wait_falls(base + 1, 200, "t4_clean");
        chk("t4_npix", 32'(pix_q.size()), 32'd2);
        chk("t4_pix0", 32'(pix_q[0]), 32'd7);
        chk("t4_pix1", 32'(pix_q[1]), 32'd8);
        chk("t4_fcnt", 32'(frame_count), 32'd1);

        // Enable dropped mid-frame, a disabled frame, then re-enable
        mon_clear();
        base = fv_falls;
        send(DT_FRAME_START, 16'h0);
        send(DT_ROW_START, 16'h0);
        send(DT_PIXEL, 16'd21);
        enable = 1'b0;
        send(DT_PIXEL, 16'd22);
        send(DT_ROW_END, 16'h0);
        send(DT_FRAME_END, 16'h0);
        idle(1);
        wait_falls(base + 1, 200, "t5_a");
        chk("t5_a_fcnt", 32'(frame_count), 32'd2);
        idle(25);
        rises0 = fv_rises;
        send(DT_FRAME_START, 16'h0);
        line(99, 1);
        send(DT_FRAME_END, 16'h0);
        idle(60);
        chk("t5_b_no_fv", 32'(fv_rises), 32'(rises0));
        chk("t5_b_fcnt", 32'(frame_count), 32'd2);
        enable = 1'b1;
        base = fv_falls;
        send(DT_FRAME_START, 16'h0);
        line(31, 1);
        send(DT_FRAME_END, 16'h0);
        idle(1);
        wait_falls(base + 1, 200, "t5_c");
        chk("t5_npix", 32'(pix_q.size()), 32'd3);
        chk("t5_pix0", 32'(pix_q[0]), 32'd21);
        chk("t5_pix1", 32'(pix_q[1]), 32'd22);
        chk("t5_pix2", 32'(pix_q[2]), 32'd31);
        chk("t5_fcnt", 32'(frame_count), 32'd3);

        // Data-valid gap, input-to-output latency, then reset mid-line
        idle(25);
        send(DT_FRAME_START, 16'h0);
        send(DT_ROW_START, 16'h0);
        send(DT_PIXEL, 16'd41);
        send(DT_PIXEL, 16'd42);
        idle(20);
        chk("t6_gap_lv", 32'(lv), 32'd1);
        chk("t6_gap_dvo", 32'(dvo), 32'd0);
        chk("t6_gap_datao", 32'(datao), 32'd0);
        send(DT_PIXEL, 16'd43);
        idle(1);
        chk("t6_lat_n", 32'(dvo), 32'd0);
        @(negedge clki);
        chk("t6_lat_n1", 32'(dvo), 32'd0);
        @(negedge clki);
        chk("t6_lat_n2_dvo", 32'(dvo), 32'd1);
        chk("t6_lat_n2_data", 32'(datao), 32'd43);
        @(negedge clki);
        resetb_clki = 1'b0;
        #1;
        chk("t6_rst_fv", 32'(fv), 32'd0);
        chk("t6_rst_lv", 32'(lv), 32'd0);
        chk("t6_rst_dvo", 32'(dvo), 32'd0);
        chk("t6_rst_datao", 32'(datao), 32'd0);
        chk("t6_rst_fcnt", 32'(frame_count), 32'd0);
        @(negedge clki);
        resetb_clki = 1'b1;
        idle(3);
        mon_clear();
        base = fv_falls;
        send(DT_PIXEL, 16'd66);
        send(DT_ROW_END, 16'h0);
        send(DT_FRAME_START, 16'h0);
        line(55, 1);
        send(DT_FRAME_END, 16'h0);
        idle(1);
        wait_falls(base + 1, 200, "t6_resume");
        chk("t6_npix", 32'(pix_q.size()), 32'd1);
        chk("t6_pix0", 32'(pix_q[0]), 32'd55);
        chk("t6_fcnt", 32'(frame_count), 32'd1);

        chk("dvo_datao_lv_rules", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
